// File: rtl/fifo_wr_gen.sv
// rtl/fifo_wr_gen.sv - FIFO write-side traffic generator (pattern, burst length, refill policy).
// Optional running checksum output enabled by defining FIFO_WR_GEN_CHKSUM_EN.
module fifo_wr_gen #(
  parameter int DATA_W      = 8,
  parameter int BURST_LEN   = 256,
  parameter int SYNC_STG    = 2,
  parameter int RESUME_MODE = 0
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              empty,
  input  logic              almost_full,
  input  logic              full,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       wr_cnt,
  output logic              overflow_err
`ifdef FIFO_WR_GEN_CHKSUM_EN
  ,
  output logic [DATA_W-1:0] chksum
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [31:0] TAPS_ALL = (DATA_W == 8)  ? 32'h0000_00B8 :
                                     (DATA_W == 16) ? 32'h0000_B400 : 32'h8020_0003;
  localparam logic [DATA_W-1:0] TAPS = TAPS_ALL[DATA_W-1:0];
  localparam logic [31:0] LAST_CNT = 32'(BURST_LEN - 1);

  logic [1:0]          state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wr_en_q, wr_en_d;
  logic                done_q, done_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic                empty_s, flag, resume, last, start_ok;

  function automatic logic [DATA_W-1:0] next_word(input logic [1:0] m, input logic [DATA_W-1:0] x);
    case (m)
      2'd0:    next_word = x + 1'b1;
      2'd1:    next_word = x - 1'b1;
      2'd2:    next_word = (x >> 1) ^ (x[0] ? TAPS : {DATA_W{1'b0}});
      default: next_word = x;
    endcase
  endfunction

  always_comb begin
    sync_d[0] = empty;
    for (int i = 1; i < SYNC_STG; i++) sync_d[i] = sync_q[i-1];
  end

  assign empty_s  = sync_q[SYNC_STG-1];
  assign flag     = almost_full | full;
  assign resume   = (RESUME_MODE == 0) ? empty_s : ~flag;
  assign last     = (BURST_LEN != 0) && (cnt_q == LAST_CNT);
  assign start_ok = (state_q == S_IDLE) && start && !stop;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q | (full & wr_en_q);

    // A word on the bus this cycle is always consumed, whatever the FSM decides next.
    if (wr_en_q) begin
      if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
      data_d = next_word(mode_q, data_q);
    end

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_WAIT;
          mode_d  = mode;
          data_d  = (mode == 2'd2 && seed == '0) ? {DATA_W{1'b1}} : seed;
          cnt_d   = 32'd0;
          ovf_d   = 1'b0;
        end
      end
      S_WAIT: begin
        if (empty_s) begin
          state_d = S_WRITE;
          wr_en_d = ~flag;
        end
      end
      S_WRITE: begin
        if (wr_en_q && last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (flag) begin
          state_d = S_HOLD;
        end else begin
          wr_en_d = 1'b1;
        end
      end
      default: begin
        if (resume) begin
          state_d = S_WRITE;
          wr_en_d = ~flag;
        end
      end
    endcase

    // Stop overrides every other transition; any write already on the bus still counts.
    if (state_q != S_IDLE && stop) begin
      state_d = S_IDLE;
      wr_en_d = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 32'd0;
      ovf_q   <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sync_q  <= sync_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_data      = data_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign wr_cnt       = cnt_q;
  assign overflow_err = ovf_q;

`ifdef FIFO_WR_GEN_CHKSUM_EN
  logic [DATA_W-1:0] chk_q;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else if (start_ok) begin
      chk_q <= '0;
    end else if (wr_en_q) begin
      chk_q <= chk_q + data_q;
    end
  end

  assign chksum = chk_q;
`endif

endmodule

// File: tb/tb_fifo_wr_gen.sv
// tb/tb_fifo_wr_gen.sv - Self-checking bench for fifo_wr_gen (8-bit, 8-word bursts, resume on empty).
// Checksum checks included when FIFO_WR_GEN_CHKSUM_EN is defined.
module tb_fifo_wr_gen;

  localparam int BL = 8;
  localparam int SS = 2;

  logic        clk_100m = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  seed = 8'd0;
  logic        empty = 1'b1;
  logic        almost_full = 1'b0;
  logic        full = 1'b0;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic [31:0] wr_cnt;
  logic        overflow_err;
`ifdef FIFO_WR_GEN_CHKSUM_EN
  logic [7:0]  chksum;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  logic [7:0] obs_q[$];

  always #5 clk_100m = ~clk_100m;

  fifo_wr_gen #(.DATA_W(8), .BURST_LEN(BL), .SYNC_STG(SS), .RESUME_MODE(0)) dut (
    .clk_100m(clk_100m), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .seed(seed),
    .empty(empty), .almost_full(almost_full), .full(full), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy), .done(done), .wr_cnt(wr_cnt), .overflow_err(overflow_err)
`ifdef FIFO_WR_GEN_CHKSUM_EN
    , .chksum(chksum)
`endif
  );

  // Every word actually written lands in obs_q, so lost or repeated words show up.
  always @(negedge clk_100m) begin
    cyc = cyc + 1;
    if (wr_en === 1'b1) begin
      obs_q.push_back(wr_data);
      last_wr_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_100m);
    #1;
  endtask

  // k-th word of a burst straight from the pattern definitions.
  function automatic logic [7:0] exp_word(input logic [1:0] m, input logic [7:0] s, input int k);
    logic [7:0] w;
    case (m)
      2'd0: return s + 8'(k);
      2'd1: return s - 8'(k);
      2'd3: return s;
      default: begin
        w = (s == 8'd0) ? 8'hFF : s;
        repeat (k) w = (w >> 1) ^ (w[0] ? 8'hB8 : 8'h00);
        return w;
      end
    endcase
  endfunction

  task automatic finish_burst(input logic [1:0] m, input logic [7:0] s, input int base,
                              input int d0, input bit rnd);
    int n;
    bit fl;
    logic [7:0] sum;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (rnd) begin
        almost_full = ($urandom_range(0, 3) == 0);
        empty = ($urandom_range(0, 4) != 0);
      end
      fl = almost_full | full;
      tick;
      n++;
      if (rnd && fl) chk("af_drop", {31'd0, wr_en}, 32'd0);
    end
    almost_full = 1'b0;
    empty = 1'b1;
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("end_cnt", wr_cnt, BL);
    chk("end_wr_en", {31'd0, wr_en}, 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);
`ifdef FIFO_WR_GEN_CHKSUM_EN
    sum = 8'd0;
    for (int k = 0; k < BL; k++) sum = sum + exp_word(m, s, k);
    chk("chksum", {24'd0, chksum}, {24'd0, sum});
`else
    sum = 8'd0;
`endif
    tick;
    tick;
    chk("done_pulses", done_cnt - d0, 32'd1);
    chk("done_timing", done_cyc, last_wr_cyc + 1);
    chk("word_count", obs_q.size() - base, BL);
    for (int k = 0; k < BL; k++)
      chk("word", (base + k < obs_q.size()) ? {24'd0, obs_q[base+k]} : 32'hDEAD,
          {24'd0, exp_word(m, s, k)});
  endtask

  task automatic run_burst(input logic [1:0] m, input logic [7:0] s, input bit rnd);
    int base, d0;
    base = obs_q.size();
    d0 = done_cnt;
    mode = m;
    seed = s;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    finish_burst(m, s, base, d0, rnd);
  endtask

  initial begin
    int base, d0, n;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr_cnt", wr_cnt, 32'd0);
    chk("rst_ovf", {31'd0, overflow_err}, 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    repeat (3) tick;

    // Patterns, including increment/decrement wrap and LFSR seed-0 substitution.
    run_burst(2'd0, 8'hFE, 1'b0);
    base = obs_q.size();
    run_burst(2'd2, 8'h00, 1'b0);
    chk("lfsr_w0", {24'd0, obs_q[base]}, 32'hFF);
    chk("lfsr_w1", {24'd0, obs_q[base+1]}, 32'hC7);
    run_burst(2'd1, 8'h02, 1'b0);
    run_burst(2'd3, 8'h5A, 1'b0);
    run_burst(2'd0, 8'h01, 1'b0);

    // Hold on almost_full, resume SYNC_STG+1 cycles after empty returns.
    base = obs_q.size();
    d0 = done_cnt;
    mode = 2'd0;
    seed = 8'h10;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (!(wr_en === 1'b1 && wr_cnt == 32'd3) && n < 50) begin
      tick;
      n++;
    end
    chk("hold_reach", wr_cnt, 32'd3);
    almost_full = 1'b1;
    empty = 1'b0;
    tick;
    chk("af_wr_en", {31'd0, wr_en}, 32'd0);
    repeat (4) begin
      tick;
      chk("hold_wr_en", {31'd0, wr_en}, 32'd0);
    end
    almost_full = 1'b0;
    empty = 1'b1;
    repeat (SS) begin
      tick;
      chk("resume_early", {31'd0, wr_en}, 32'd0);
    end
    tick;
    chk("resume_wr_en", {31'd0, wr_en}, 32'd1);
    chk("resume_data", {24'd0, wr_data}, 32'h14);
    finish_burst(2'd0, 8'h10, base, d0, 1'b0);

    // Overflow: sticky through stop, cleared by the next start.
    mode = 2'd0;
    seed = 8'h30;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (wr_en !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    full = 1'b1;
    tick;
    chk("ovf_set", {31'd0, overflow_err}, 32'd1);
    chk("ovf_wr_en", {31'd0, wr_en}, 32'd0);
    full = 1'b0;
    tick;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("ovf_stop_done", {31'd0, done}, 32'd1);
    chk("ovf_stop_busy", {31'd0, busy}, 32'd0);
    tick;
    chk("ovf_sticky", {31'd0, overflow_err}, 32'd1);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("ovf_clear", {31'd0, overflow_err}, 32'd0);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    tick;

    // Stop beats start in IDLE; start ignored while busy; stop mid-burst.
    d0 = done_cnt;
    start = 1'b1;
    stop = 1'b1;
    tick;
    start = 1'b0;
    stop = 1'b0;
    chk("ss_busy", {31'd0, busy}, 32'd0);
    chk("ss_done", {31'd0, done}, 32'd0);
    mode = 2'd0;
    seed = 8'h40;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (wr_cnt != 32'd2 && n < 20) begin
      tick;
      n++;
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_ignored", wr_cnt, 32'd3);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("stop_done", {31'd0, done}, 32'd1);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_wr_en", {31'd0, wr_en}, 32'd0);
    chk("stop_cnt", wr_cnt, 32'd4);
    tick;
    tick;
    chk("stop_one_done", done_cnt - d0, 32'd1);

    // Asynchronous reset mid-burst, observed between clock edges.
    d0 = done_cnt;
    seed = 8'h77;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    @(negedge clk_100m);
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("arst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_wr_cnt", wr_cnt, 32'd0);
`ifdef FIFO_WR_GEN_CHKSUM_EN
    chk("arst_chksum", {24'd0, chksum}, 32'd0);
`endif
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    chk("arst_no_done", done_cnt - d0, 32'd0);

    // Randomised bursts with random flag activity.
    repeat (8) run_burst(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
